// File: rtl/condicionador_chaves_pkg.sv
// Shared types and default sizing for the switch conditioner.
package condicionador_pkg;

  // Per-channel debounce states: two stable levels, each with a confirmation state
  typedef enum logic [1:0] {
    EST_0  = 2'd0,
    CONF_1 = 2'd1,
    EST_1  = 2'd2,
    CONF_0 = 2'd3
  } estado_deb_t;

  localparam int unsigned NCH_PADRAO      = 5;
  localparam int unsigned DEBOUNCE_PADRAO = 4;

endpackage

// File: rtl/condicionador_chaves_debounce.sv
// One switch channel: 2-flop synchroniser, debounce FSM, confirm counter, edge pulses.
module debounce_canal
  import condicionador_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_PADRAO
) (
  input  logic clk_2,
  input  logic reset,
  input  logic swi,
  output logic estavel,
  output logic subida,
  output logic descida
);

  localparam int unsigned   CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ULT = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          s;
  estado_deb_t   estado, estado_prox;
  logic [CW-1:0] cnt, cnt_prox;
  logic          subida_prox, descida_prox;

  // Synchronise the raw level into clk_2; nothing sits between the two flops
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      s    <= 1'b0;
    end else begin
      meta <= swi;
      s    <= meta;
    end
  end

  // FSM state, confirm counter and registered event pulses
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      estado  <= EST_0;
      cnt     <= '0;
      subida  <= 1'b0;
      descida <= 1'b0;
    end else begin
      estado  <= estado_prox;
      cnt     <= cnt_prox;
      subida  <= subida_prox;
      descida <= descida_prox;
    end
  end

  // Next state: a change is accepted only after DEBOUNCE_CYCLES consecutive samples
  always_comb begin
    estado_prox  = estado;
    cnt_prox     = '0;
    subida_prox  = 1'b0;
    descida_prox = 1'b0;
    case (estado)
      EST_0: begin
        if (s) begin
          estado_prox = CONF_1;
          cnt_prox    = CW'(1);
        end
      end
      CONF_1: begin
        if (!s) begin
          estado_prox = EST_0;
        end else if (cnt == CNT_ULT) begin
          estado_prox = EST_1;
          subida_prox = 1'b1;
        end else begin
          cnt_prox = cnt + 1'b1;
        end
      end
      EST_1: begin
        if (!s) begin
          estado_prox = CONF_0;
          cnt_prox    = CW'(1);
        end
      end
      CONF_0: begin
        if (s) begin
          estado_prox = EST_1;
        end else if (cnt == CNT_ULT) begin
          estado_prox  = EST_0;
          descida_prox = 1'b1;
        end else begin
          cnt_prox = cnt + 1'b1;
        end
      end
      default: estado_prox = EST_0;
    endcase
  end

  assign estavel = (estado == EST_1) || (estado == CONF_0);

endmodule

// File: rtl/condicionador_chaves.sv
// Switch input conditioner: NCH independent debounced channels plus an any-event flag.
module condicionador_chaves
  import condicionador_pkg::*;
#(
  parameter int unsigned NCH             = NCH_PADRAO,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_PADRAO
) (
  input  logic           clk_2,
  input  logic           reset,
  input  logic [NCH-1:0] swi_in,
  output logic [NCH-1:0] sw_estavel,
  output logic [NCH-1:0] sw_subida,
  output logic [NCH-1:0] sw_descida,
  output logic           qualquer_evento
);

  for (genvar i = 0; i < NCH; i++) begin : g_canal
    debounce_canal #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_canal (
      .clk_2   (clk_2),
      .reset   (reset),
      .swi     (swi_in[i]),
      .estavel (sw_estavel[i]),
      .subida  (sw_subida[i]),
      .descida (sw_descida[i])
    );
  end

  assign qualquer_evento = |{sw_subida, sw_descida};

endmodule

// File: tb/tb_condicionador_chaves.sv
// Bench for condicionador_chaves: directed scenarios then random toggling, against a run-length model.
module tb_condicionador_chaves;

  localparam int unsigned NCH = 5;
  localparam int unsigned DEB = 4;

  logic           clk_2 = 1'b0;
  logic           reset = 1'b0;
  logic [NCH-1:0] swi_in = '0;
  logic [NCH-1:0] sw_estavel, sw_subida, sw_descida;
  logic           qualquer_evento;

  int total = 0;
  int bad   = 0;

  // Reference model: the synchronised level is the raw sample from two edges ago;
  // a channel flips once its sampled level has differed from the stable one DEB times in a row.
  logic [NCH-1:0] hist[$];
  logic [NCH-1:0] m_est, m_sub, m_desc;
  int unsigned    run[NCH];

  condicionador_chaves #(
    .NCH             (NCH),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk_2           (clk_2),
    .reset           (reset),
    .swi_in          (swi_in),
    .sw_estavel      (sw_estavel),
    .sw_subida       (sw_subida),
    .sw_descida      (sw_descida),
    .qualquer_evento (qualquer_evento)
  );

  always #5 clk_2 = ~clk_2;

  task automatic model_reset();
    hist.delete();
    m_est  = '0;
    m_sub  = '0;
    m_desc = '0;
    foreach (run[i]) run[i] = 0;
  endtask

  task automatic model_edge();
    logic [NCH-1:0] s;
    s = (hist.size() >= 2) ? hist[1] : '0;
    hist.push_front(swi_in);
    if (hist.size() > 2) void'(hist.pop_back());
    m_sub  = '0;
    m_desc = '0;
    for (int i = 0; i < NCH; i++) begin
      if (s[i] != m_est[i]) run[i]++;
      else run[i] = 0;
      if (run[i] == DEB) begin
        m_est[i] = ~m_est[i];
        if (m_est[i]) m_sub[i] = 1'b1;
        else m_desc[i] = 1'b1;
        run[i] = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [NCH-1:0] obs, input logic [NCH-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_estavel"}, sw_estavel, m_est);
    chk({tag, "_subida"}, sw_subida, m_sub);
    chk({tag, "_descida"}, sw_descida, m_desc);
    chk1({tag, "_evento"}, qualquer_evento, |(m_sub | m_desc));
  endtask

  task automatic tick(input string tag);
    @(posedge clk_2);
    if (reset) model_reset();
    else model_edge();
    #1;
    check_outputs(tag);
  endtask

  initial begin
    logic [5:0] pat;
    int         pulse_edge;
    int         pulse_cnt;

    // Asynchronous reset with all switches high
    swi_in = '1;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs("reset_async");
    for (int k = 0; k < 3; k++) tick("reset_hold");

    // Switches held high across release are re-debounced and pulse normally
    #1 reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick("hold_rel");
      if (k == 5) chk("hold_rel_pre", sw_estavel, '0);
    end
    chk("hold_rel_sub", sw_subida, '1);
    swi_in = '0;
    for (int k = 0; k < 8; k++) tick("drain0");

    // Clean press on channel 2
    swi_in = 5'b00100;
    for (int k = 1; k <= 6; k++) begin
      tick("press");
      if (k == 5) chk1("press_pre", sw_estavel[2], 1'b0);
    end
    chk("press_est", sw_estavel, 5'b00100);
    chk("press_sub", sw_subida, 5'b00100);
    chk1("press_evt", qualquer_evento, 1'b1);
    tick("press_after");
    chk("press_sub_end", sw_subida, '0);

    // Three-cycle glitch on channel 0 is rejected
    swi_in[0] = 1'b1;
    for (int k = 0; k < 3; k++) tick("glitch");
    swi_in[0] = 1'b0;
    for (int k = 0; k < 8; k++) tick("glitch_after");
    chk1("glitch_est", sw_estavel[0], 1'b0);

    // Bounce 1,0,1,1,1,1 on channel 1: one pulse, at edge 8 counting from the first sample
    pat        = 6'b111101;
    pulse_edge = -1;
    pulse_cnt  = 0;
    for (int e = 1; e <= 14; e++) begin
      swi_in[1] = (e <= 6) ? pat[e-1] : 1'b1;
      tick("bounce");
      if (sw_subida[1]) begin
        pulse_cnt++;
        pulse_edge = e;
      end
    end
    chk1("bounce_est", sw_estavel[1], 1'b1);
    total++;
    assert (pulse_cnt == 1 && pulse_edge == 8) else begin
      bad++;
      $error("FAIL bounce_pulse observed=count %0d at edge %0d expected=count 1 at edge 8", pulse_cnt, pulse_edge);
    end

    // Release on channel 3
    swi_in[3] = 1'b1;
    for (int k = 0; k < 8; k++) tick("rel_setup");
    swi_in[3] = 1'b0;
    for (int k = 1; k <= 6; k++) tick("release");
    chk1("release_est", sw_estavel[3], 1'b0);
    chk("release_desc", sw_descida, 5'b01000);
    chk("release_sub", sw_subida, '0);
    tick("release_after");
    chk("release_desc_end", sw_descida, '0);

    // Reset during confirmation, then simultaneous acceptance on channels 0 and 4
    swi_in = '0;
    for (int k = 0; k < 10; k++) tick("drain1");
    swi_in = 5'b10001;
    for (int k = 0; k < 4; k++) tick("mid_conf");
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("mid_reset");
    tick("mid_reset_hold");
    #1 reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick("post_reset");
      if (k < 6) chk("post_reset_quiet", sw_subida, '0);
    end
    chk("post_reset_est", sw_estavel, 5'b10001);
    chk("post_reset_sub", sw_subida, 5'b10001);

    // Random toggling, mixing short glitches and long holds
    for (int t = 0; t < 600; t++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(7) == 0) swi_in[c] = ~swi_in[c];
      tick("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/condicionador_chaves.md
Name: condicionador_chaves

Overview:
- Input conditioner for the board switches, placed upstream of the 4-bit counter block.
- Synchronises each raw SWI bit to clk_2 and debounces it with a per-channel state machine.
- Outputs clean stable levels (reset/decrescente/incr_3/congelamento/saturacao controls) plus single-cycle rising/falling event pulses.
- Counter block consumes sw_estavel directly; sw_subida can serve as a step/enable strobe.

Parameters:
- NCH, 5, number of switch channels conditioned (SWI[NCH-1:0]).
- DEBOUNCE_CYCLES, 4, consecutive synchronised samples at new level needed to accept a change; legal range 2..255.
- CW, $clog2(DEBOUNCE_CYCLES+1), width of per-channel confirm counter (derived, not overridden).

Ports:
- clk_2  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- swi_in  input  NCH  raw switch levels, asynchronous to clk_2.
- sw_estavel  output  NCH  debounced level per channel (registered).
- sw_subida  output  NCH  one-cycle pulse on accepted 0->1 of sw_estavel (registered).
- sw_descida  output  NCH  one-cycle pulse on accepted 1->0 of sw_estavel (registered).
- qualquer_evento  output  1  OR of all sw_subida and sw_descida bits (combinational from registered bits).

Behaviour:
- Reset (async assert, sync release on clk_2): both sync flops=0, all FSMs=EST_0, counters=0, sw_estavel/sw_subida/sw_descida=0; qualquer_evento=0 consequently.
- Sync: 2-flop chain per channel; s[i] = second flop. No logic between flops.
- Per-channel FSM states: EST_0, CONF_1, EST_1, CONF_0; sw_estavel=1 in EST_1 and CONF_0, else 0.
- EST_0: s=1 -> CONF_1, cnt=1; else stay, cnt=0.
- CONF_1: s=0 -> EST_0, cnt=0 (glitch rejected, no pulse); s=1 and cnt==DEBOUNCE_CYCLES-1 -> EST_1, sw_subida=1 next cycle, cnt=0; else cnt+1.
- EST_1 / CONF_0: mirror image with s inverted; accepted transition to EST_0 asserts sw_descida for one cycle.
- sw_subida/sw_descida are high for exactly one clk_2 cycle per accepted transition; never both high on the same channel.
- Latency: new raw level held steady from the first sampling edge (edge 1) -> sw_estavel changes after edge DEBOUNCE_CYCLES+2 (6 with default); pulse is coincident with that cycle.
- Rejection: any return of s to the stable level before DEBOUNCE_CYCLES consecutive samples restarts confirmation from zero; pulses shorter than DEBOUNCE_CYCLES cycles at s never propagate.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap possible.
- Channels fully independent; simultaneous changes on several channels produce simultaneous pulses.
- Reset mid-confirmation: FSM returns to EST_0 immediately, no pulse. Switch held high across reset release is re-debounced and produces a normal sw_subida.

Decomposition:
- Package condicionador_pkg: typedef enum logic [1:0] estado_deb_t {EST_0, CONF_1, EST_1, CONF_0}; default constants NCH_PADRAO=5, DEBOUNCE_PADRAO=4.
- Sub-module debounce_canal: one channel covering sync chain, FSM, counter and pulse regs.
- Top instantiates NCH copies via generate and ORs the pulses.

Test Plan:
- Reset: assert reset with swi_in=5'b11111 -> all outputs 0 asynchronously; held 0 while reset=1.
- Clean press: release reset, swi_in[2] 0->1 held -> sw_estavel[2]=1 after 6th edge; sw_subida[2]=1 exactly that one cycle; qualquer_evento=1 same cycle; other bits 0.
- Glitch: swi_in[0]=1 for 3 cycles then 0 -> sw_estavel[0], sw_subida[0] stay 0 throughout.
- Bounce then settle: swi_in[1] pattern 1,0,1,1,1,1 (per cycle) -> single sw_subida[1], 6 edges after the last 0->1; no extra pulses.
- Release: from sw_estavel[3]=1, swi_in[3]->0 held -> sw_estavel[3]=0 after 6 edges with one-cycle sw_descida[3], sw_subida[3]=0.
- Reset mid-confirm and simultaneity: swi_in=5'b10001 held, assert reset at 2nd confirm cycle, release -> both channels restart, sw_estavel=5'b10001 6 edges after release, sw_subida[0] and [4] pulse in the same cycle.
